// File: rtl/scpu_pkg.sv
// Shared types and sizes for the sCPU program loader / run controller.
// Instruction memory geometry, cycle counter width and controller state encoding.
package scpu_pkg;

  localparam int unsigned IMEM_DEPTH = 16;
  localparam int unsigned IMEM_AW    = 4;
  localparam int unsigned INST_W     = 8;
  localparam int unsigned CYC_W      = 16;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StResetCore,
    StRun,
    StDone
  } state_e;

  // Width of the byte counter: must hold IMEM_DEPTH itself, not just IMEM_DEPTH-1.
  localparam int unsigned LCNT_W = IMEM_AW + 1;

endpackage

// File: rtl/scpu_halt_detect.sv
// Halt detector: flags a branch-to-self when the core pc repeats on consecutive run cycles.
// The first enabled cycle after clr never reports a halt, since pc_prev is not yet valid.
module scpu_halt_detect
  import scpu_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               en,
  input  logic [IMEM_AW-1:0] core_pc,
  output logic               halt
);

  logic [IMEM_AW-1:0] pc_prev_q;
  logic               first_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_prev_q <= '0;
      first_q   <= 1'b1;
    end else if (clr) begin
      pc_prev_q <= '0;
      first_q   <= 1'b1;
    end else if (en) begin
      pc_prev_q <= core_pc;
      first_q   <= 1'b0;
    end
  end

  assign halt = en && !first_q && (core_pc == pc_prev_q);

endmodule

// File: rtl/scpu_run_ctrl.sv
// Program loader and run controller for the 8-bit sCPU core: streams bytes into imem while the
// core is held in reset, then runs the core until it halts or exhausts its cycle budget.
module scpu_run_ctrl
  import scpu_pkg::*;
#(
  parameter int unsigned MAX_CYCLES = 1000,
  parameter int unsigned RST_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_start,
  input  logic               load_valid,
  input  logic [INST_W-1:0]  load_data,
  input  logic               load_last,
  output logic               load_ready,
  input  logic               run_start,
  input  logic               abort,
  output logic               imem_we,
  output logic [IMEM_AW-1:0] imem_addr,
  output logic [INST_W-1:0]  imem_wdata,
  output logic               core_rst,
  input  logic [IMEM_AW-1:0] core_pc,
  input  logic               core_ok,
  output logic               busy,
  output logic               done,
  output logic               result_ok,
  output logic               timeout,
  output logic [CYC_W-1:0]   cycles,
  output logic [LCNT_W-1:0]  load_count
);

  localparam logic [CYC_W-1:0]  RstLast  = CYC_W'(RST_CYCLES - 1);
  localparam logic [CYC_W-1:0]  MaxLast  = CYC_W'(MAX_CYCLES - 1);
  localparam logic [LCNT_W-1:0] LastByte = LCNT_W'(IMEM_DEPTH - 1);

  state_e              state_q, state_d;
  logic [LCNT_W-1:0]   load_count_q, load_count_d;
  logic [CYC_W-1:0]    cycles_q, cycles_d;
  logic [CYC_W-1:0]    rst_cnt_q, rst_cnt_d;
  logic                result_ok_q, result_ok_d;
  logic                timeout_q, timeout_d;
  logic                imem_we_q, imem_we_d;
  logic [IMEM_AW-1:0]  imem_addr_q, imem_addr_d;
  logic [INST_W-1:0]   imem_wdata_q, imem_wdata_d;
  logic                hd_clr, hd_en, halt;
  logic                xfer;

  scpu_halt_detect u_halt_detect (
    .clk     (clk),
    .rst     (rst),
    .clr     (hd_clr),
    .en      (hd_en),
    .core_pc (core_pc),
    .halt    (halt)
  );

  // Ready depends only on state and abort so an aborting cycle can never complete a transfer.
  assign load_ready = (state_q == StLoad) && !abort;
  assign xfer       = load_valid && load_ready;

  always_comb begin
    state_d      = state_q;
    load_count_d = load_count_q;
    cycles_d     = cycles_q;
    rst_cnt_d    = rst_cnt_q;
    result_ok_d  = result_ok_q;
    timeout_d    = timeout_q;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;
    hd_clr       = 1'b0;
    hd_en        = 1'b0;

    if (abort) begin
      state_d      = StIdle;
      load_count_d = '0;
      cycles_d     = '0;
      result_ok_d  = 1'b0;
      timeout_d    = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (load_start) begin
            state_d      = StLoad;
            load_count_d = '0;
          end else if (run_start) begin
            state_d   = StResetCore;
            rst_cnt_d = '0;
          end
        end

        StLoad: begin
          if (xfer) begin
            imem_we_d    = 1'b1;
            imem_addr_d  = load_count_q[IMEM_AW-1:0];
            imem_wdata_d = load_data;
            load_count_d = load_count_q + LCNT_W'(1);
            if (load_last || (load_count_q == LastByte)) begin
              state_d = StIdle;
            end
          end
        end

        StResetCore: begin
          cycles_d    = '0;
          result_ok_d = 1'b0;
          timeout_d   = 1'b0;
          hd_clr      = 1'b1;
          if (rst_cnt_q == RstLast) begin
            state_d = StRun;
          end else begin
            rst_cnt_d = rst_cnt_q + CYC_W'(1);
          end
        end

        StRun: begin
          hd_en    = 1'b1;
          cycles_d = cycles_q + CYC_W'(1);
          // Halt wins over budget exhaustion detected in the same cycle.
          if (halt) begin
            result_ok_d = core_ok;
            state_d     = StDone;
          end else if (cycles_q == MaxLast) begin
            timeout_d   = 1'b1;
            result_ok_d = 1'b0;
            state_d     = StDone;
          end
        end

        StDone: begin
          if (run_start) begin
            state_d   = StResetCore;
            rst_cnt_d = '0;
          end
        end

        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      load_count_q <= '0;
      cycles_q     <= '0;
      rst_cnt_q    <= '0;
      result_ok_q  <= 1'b0;
      timeout_q    <= 1'b0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
    end else begin
      state_q      <= state_d;
      load_count_q <= load_count_d;
      cycles_q     <= cycles_d;
      rst_cnt_q    <= rst_cnt_d;
      result_ok_q  <= result_ok_d;
      timeout_q    <= timeout_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
    end
  end

  assign imem_we    = imem_we_q;
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
  assign core_rst   = (state_q != StRun);
  assign busy       = (state_q == StLoad) || (state_q == StResetCore) || (state_q == StRun);
  assign done       = (state_q == StDone);
  assign result_ok  = result_ok_q;
  assign timeout    = timeout_q;
  assign cycles     = cycles_q;
  assign load_count = load_count_q;

endmodule
